mem_stage_lsx: RTL and testbench
================================

# mem_stage_lsx

Parametrised memory-access pipeline stage between EX and WB. It accepts a decoded instruction from EX and waits for the SRAM-like data response when the instruction issued a load or store. It aligns and sign/zero-extends load data by byte offset, and buffers returned data while WB back-pressures. It also tolerates pipeline flushes with outstanding requests, and drives a forward/block bus to ID that distinguishes "result ready" from "result pending".

## Interface
- `DATA_W`, 32: datapath width, 32 or 64; `OFF_W = log2(DATA_W/8)`.
- `PC_W`, 32: PC width.
- `DEST_W`, 5: register-index width.
- `DISC_W`, 2: width of the discard counter; up to 2^DISC_W−1 stale responses are tracked.
- `ES_W` = 6+DEST_W+DATA_W+PC_W. `MS_W` = 1+DEST_W+DATA_W+PC_W. `FWD_W` = 2+DEST_W+DATA_W.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ws_allowin` in 1: WB can accept.
- `ms_allowin` out 1: this stage can accept.
- `es_to_ms_valid` in 1: EX presents an instruction.
- `es_to_ms_bus` in ES_W: {mem_req, ld_type[2:0], res_from_mem, gr_we, dest, alu_result, pc}, MSB first.
- `flush` in 1: exception/ERET flush from WB.
- `data_sram_data_ok` in 1: data response strobe.
- `data_sram_rdata` in DATA_W: response data, valid with data_ok.
- `ms_to_ws_valid` out 1.
- `ms_to_ws_bus` out MS_W: {gr_we, dest, final_result, pc}.
- `ms_fwd_blk_bus` out FWD_W: {fwd_valid, fwd_blk, dest, data}.

## Operation
- `mem_req=1`: EX issued a data request for this instruction (load or store). One response is owed.
- ld_type encoding:
  - 000 native word
  - 001 LB
  - 010 LBU
  - 011 LH
  - 100 LHU
  - 101 LW, sign-extended
  - 110 LWU
  - 111 reserved; treated as 000
  - For DATA_W=32, 101 and 110 behave as 000.
- Alignment:
  - `off = alu_result[OFF_W-1:0]`.
  - The selected lane starts at byte `off`, little-endian.
  - Halfword uses `off` with its LSB ignored; word uses `off` with its low 2 bits ignored.
  - The result is extended to DATA_W.
- `final_result` = aligned load data if `res_from_mem`, else `alu_result`.
- State registers:
  - `ms_valid`
  - `bus_r` (captured fields)
  - `got_data`: the response for the current instruction has arrived
  - `rdata_buf` (DATA_W)
  - `disc_cnt` (DISC_W)
- Response routing, each cycle `data_sram_data_ok=1`:
  - if `disc_cnt≠0`: the response is stale. Decrement `disc_cnt` and do not deliver it.
  - else if `ms_valid && mem_req && !got_data`: deliver it. Capture `rdata_buf` and set `got_data` unless the instruction leaves this cycle.
  - else: protocol error. Ignore it; the bench asserts this never happens.
- `need_wait = ms_valid && mem_req && !got_data && !(data_ok && disc_cnt==0)`.
- `ms_ready_go = !need_wait`. Load data source is `rdata_buf` if `got_data`, else `data_sram_rdata`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !flush`.
- Acceptance occurs when `es_to_ms_valid && ms_allowin && !flush`. On acceptance, load `bus_r` and clear `got_data`.
- `flush`:
  - next-cycle `ms_valid=0` and `got_data=0`; no acceptance that cycle.
  - if the current instruction owed a response that has not arrived (and is not arriving this cycle), increment `disc_cnt`.
  - flush plus a stale data_ok in the same cycle: the net `disc_cnt` change is computed as +1 −1.
  - `disc_cnt` saturates; overflow is a bench assertion.
- Forward bus:
  - `fwd_valid = ms_valid && gr_we`.
  - `fwd_blk = fwd_valid && res_from_mem && need_wait`, so ID must stall.
  - `data = final_result`.

## Timing
- Reset (async assert, sync deassert external): `ms_valid=0`, `got_data=0`, `disc_cnt=0`, `bus_r=0`, `rdata_buf=0`.
- Output values during reset: `ms_allowin=1`, `ms_to_ws_valid=0`, `fwd_valid=0`, `fwd_blk=0`.
- Non-memory instruction: 1 cycle in stage when WB is ready.
- Memory instruction with data_ok in its first cycle: 1 cycle. The data path is combinational from `data_sram_rdata` to `ms_to_ws_bus`.
- data_ok arriving N cycles late: N+1 cycles in stage.
- data arrives while `ws_allowin=0`: data is held in `rdata_buf`. Later release uses buffered data; `data_sram_rdata` is don't-care.
- Reset mid-wait: all state clears, including `disc_cnt`. The memory interface is reset concurrently.

## Structure
- Shared definitions header holds:
  - ld_type encodings
  - ES/MS/FWD bus width macros derived from DATA_W/DEST_W/PC_W
  - bus field offsets
- Sub-module `load_align`: purely combinational (rdata, off, ld_type) → extended data, parametrised by DATA_W.
- Everything else lives in `mem_stage_lsx`, in one always block with async reset plus combinational assigns.

## Test plan
- LB at offset 3, rdata=0x80FF1234, data_ok in the first cycle → final_result=0xFFFFFF80 in the same cycle; LBU → 0x00000080.
- LHU at offset 2, rdata=0x80FF1234 → 0x000080FF; LH → 0xFFFF80FF; LW → 0x80FF1234.
- Load with data_ok 3 cycles late → `fwd_blk=1` for 3 cycles, `ms_to_ws_valid` rises in cycle 4 with correct data.
- data_ok arrives with `ws_allowin=0` for 2 cycles, and rdata changes afterwards → WB receives the originally returned value.
- Flush while a load is waiting, then a new load enters. First data_ok (0xDEAD) is discarded and `disc_cnt` returns to 0; second data_ok (0x1234) is delivered to the new load.
- DATA_W=64 with LWU at offset 4, rdata=0x89ABCDEF_01234567 → 0x00000000_89ABCDEF; with LW → 0xFFFFFFFF_89ABCDEF.

Source files
------------

// File: rtl/mem_stage_lsx_pkg.sv
// Shared load-type encodings and bus-width helpers for the
// memory-access stage.
package mem_stage_lsx_pkg;

    localparam logic [2:0] LD_NAT = 3'b000;
    localparam logic [2:0] LD_B   = 3'b001;
    localparam logic [2:0] LD_BU  = 3'b010;
    localparam logic [2:0] LD_H   = 3'b011;
    localparam logic [2:0] LD_HU  = 3'b100;
    localparam logic [2:0] LD_W   = 3'b101;
    localparam logic [2:0] LD_WU  = 3'b110;

    // es bus: {mem_req, ld_type, res_from_mem, gr_we, dest, alu, pc}
    localparam int ES_CTRL_W = 6;

    function automatic int es_w(int data_w, int dest_w, int pc_w);
        return ES_CTRL_W + dest_w + data_w + pc_w;
    endfunction

    function automatic int ms_w(int data_w, int dest_w, int pc_w);
        return 1 + dest_w + data_w + pc_w;
    endfunction

    function automatic int fwd_w(int data_w, int dest_w);
        return 2 + dest_w + data_w;
    endfunction

endpackage

// File: rtl/mem_stage_lsx_if.sv
// EX->MEM->WB handshake, data-SRAM response and ID forward bus
// as seen by the memory-access stage.
interface mem_stage_lsx_if
    import mem_stage_lsx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5
);
    localparam int ES_W  = es_w(DATA_W, DEST_W, PC_W);
    localparam int MS_W  = ms_w(DATA_W, DEST_W, PC_W);
    localparam int FWD_W = fwd_w(DATA_W, DEST_W);

    logic              es_to_ms_valid;
    logic [ES_W-1:0]   es_to_ms_bus;
    logic              ms_allowin;
    logic              ms_to_ws_valid;
    logic [MS_W-1:0]   ms_to_ws_bus;
    logic              ws_allowin;
    logic              flush;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic [FWD_W-1:0]  ms_fwd_blk_bus;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, flush,
        input  data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
        output ms_fwd_blk_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, flush,
        output data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
        input  ms_fwd_blk_bus
    );

endinterface

// File: rtl/mem_stage_lsx_load_align.sv
// Selects the addressed byte/half/word lane of a little-endian
// load response and sign- or zero-extends it to DATA_W.
module load_align
    import mem_stage_lsx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] data
);
    logic [OFF_W+2:0] b_sh;
    logic [OFF_W+2:0] h_sh;
    logic [OFF_W+2:0] w_sh;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;

    assign b_sh = {off, 3'b000};
    assign h_sh = {off & ~OFF_W'(1), 3'b000};
    assign w_sh = {off & ~OFF_W'(3), 3'b000};
    assign b    = rdata[b_sh +: 8];
    assign h    = rdata[h_sh +: 16];
    assign w    = rdata[w_sh +: 32];

    // On a 32-bit datapath the word cases collapse to the native word.
    always_comb begin
        data = rdata;
        unique case (ld_type)
            LD_B:    data = DATA_W'($signed(b));
            LD_BU:   data = DATA_W'(b);
            LD_H:    data = DATA_W'($signed(h));
            LD_HU:   data = DATA_W'(h);
            LD_W:    data = DATA_W'($signed(w));
            LD_WU:   data = DATA_W'(w);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsx.sv
// Memory-access pipeline stage: waits for the data response, buffers
// it under WB back-pressure and discards responses orphaned by flush.
module mem_stage_lsx
    import mem_stage_lsx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5,
    parameter int DISC_W = 2
) (
    input  logic          clk,
    input  logic          resetn,
    mem_stage_lsx_if.slave io
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int ES_W  = es_w(DATA_W, DEST_W, PC_W);
    localparam logic [DISC_W-1:0] DISC_MAX = '1;

    logic              ms_valid;
    logic              got_data;
    logic [ES_W-1:0]   bus_r;
    logic [DATA_W-1:0] rdata_buf;
    logic [DISC_W-1:0] disc_cnt;

    logic              mem_req;
    logic [2:0]        ld_type;
    logic              res_from_mem;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [PC_W-1:0]   pc;

    assign {mem_req, ld_type, res_from_mem, gr_we,
            dest, alu_result, pc} = bus_r;

    logic              fresh_ok;
    logic              stale_ok;
    logic              deliver;
    logic              need_wait;
    logic              ms_ready_go;
    logic              accept;
    logic              disc_inc;
    logic [DATA_W-1:0] ld_src;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] final_result;
    logic              fwd_valid;
    logic              fwd_blk;

    assign fresh_ok    = io.data_sram_data_ok && disc_cnt == '0;
    assign stale_ok    = io.data_sram_data_ok && disc_cnt != '0;
    assign deliver     = fresh_ok && ms_valid && mem_req && !got_data;
    assign need_wait   = ms_valid && mem_req && !got_data && !fresh_ok;
    assign ms_ready_go = !need_wait;
    assign accept      = io.es_to_ms_valid && io.ms_allowin && !io.flush;
    assign disc_inc    = io.flush && need_wait;

    assign io.ms_allowin     = !ms_valid || (ms_ready_go && io.ws_allowin);
    assign io.ms_to_ws_valid = ms_valid && ms_ready_go && !io.flush;

    assign ld_src = got_data ? rdata_buf : io.data_sram_rdata;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata   (ld_src),
        .off     (alu_result[OFF_W-1:0]),
        .ld_type (ld_type),
        .data    (ld_data)
    );

    assign final_result = res_from_mem ? ld_data : alu_result;
    assign fwd_valid    = ms_valid && gr_we;
    assign fwd_blk      = fwd_valid && res_from_mem && need_wait;

    assign io.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign io.ms_fwd_blk_bus = {fwd_valid, fwd_blk, dest, final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            got_data  <= 1'b0;
            bus_r     <= '0;
            rdata_buf <= '0;
            disc_cnt  <= '0;
        end else begin
            if (io.flush) begin
                ms_valid <= 1'b0;
            end else if (io.ms_allowin) begin
                ms_valid <= io.es_to_ms_valid;
            end
            if (accept) begin
                bus_r <= io.es_to_ms_bus;
            end
            // allowin with an occupied stage means it is leaving now
            if (io.flush || io.ms_allowin) begin
                got_data <= 1'b0;
            end else if (deliver) begin
                got_data  <= 1'b1;
                rdata_buf <= io.data_sram_rdata;
            end
            if (disc_inc && !stale_ok && disc_cnt != DISC_MAX) begin
                disc_cnt <= disc_cnt + 1'b1;
            end else if (stale_ok && !disc_inc) begin
                disc_cnt <= disc_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsx.sv
// Directed checks of the memory-access stage on 32- and 64-bit
// datapaths.
module tb_mem_stage_lsx;
    import mem_stage_lsx_pkg::*;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    mem_stage_lsx_if #(.DATA_W(32)) i32 ();
    mem_stage_lsx_if #(.DATA_W(64)) i64 ();

    mem_stage_lsx #(.DATA_W(32)) d32 (
        .clk    (clk),
        .resetn (resetn),
        .io     (i32)
    );

    mem_stage_lsx #(.DATA_W(64)) d64 (
        .clk    (clk),
        .resetn (resetn),
        .io     (i64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] mk32(
        input logic mr, input logic [2:0] ld, input logic rfm,
        input logic [31:0] alu, input logic [31:0] pc);
        return {mr, ld, rfm, 1'b1, 5'd7, alu, pc};
    endfunction

    function automatic logic [106:0] mk64(
        input logic [2:0] ld, input logic [63:0] alu);
        return {1'b1, ld, 1'b1, 1'b1, 5'd9, alu, 32'h200};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        chk("rst_allowin", 64'(i32.ms_allowin), 64'd1);
        chk("rst_to_ws_valid", 64'(i32.ms_to_ws_valid), 64'd0);
        chk("rst_fwd_valid", 64'(i32.ms_fwd_blk_bus[38]), 64'd0);
        chk("rst_fwd_blk", 64'(i32.ms_fwd_blk_bus[37]), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_alu();
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b0, LD_NAT, 1'b0, 32'h55, 32'h104);
        step();
        i32.es_to_ms_valid = 1'b0;
        #1;
        chk("alu_valid", 64'(i32.ms_to_ws_valid), 64'd1);
        chk("alu_result", 64'(i32.ms_to_ws_bus[63:32]), 64'h55);
        chk("alu_pc", 64'(i32.ms_to_ws_bus[31:0]), 64'h104);
        chk("alu_fwd_valid", 64'(i32.ms_fwd_blk_bus[38]), 64'd1);
        chk("alu_fwd_blk", 64'(i32.ms_fwd_blk_bus[37]), 64'd0);
        step();
        chk("alu_drained", 64'(i32.ms_to_ws_valid), 64'd0);
    endtask

    task automatic load_now(input logic [2:0] ld, input logic [31:0] alu,
                            input logic [31:0] rd, input logic [31:0] exp,
                            input string nm);
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, ld, 1'b1, alu, 32'h108);
        step();
        i32.es_to_ms_valid    = 1'b0;
        i32.data_sram_data_ok = 1'b1;
        i32.data_sram_rdata   = rd;
        #1;
        chk({nm, "_valid"}, 64'(i32.ms_to_ws_valid), 64'd1);
        chk(nm, 64'(i32.ms_to_ws_bus[63:32]), 64'(exp));
        step();
        i32.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_align();
        load_now(LD_B,  32'h1003, 32'h80FF1234, 32'hFFFFFF80, "lb3");
        load_now(LD_BU, 32'h1003, 32'h80FF1234, 32'h00000080, "lbu3");
        load_now(LD_HU, 32'h1002, 32'h80FF1234, 32'h000080FF, "lhu2");
        load_now(LD_H,  32'h1002, 32'h80FF1234, 32'hFFFF80FF, "lh2");
        load_now(LD_W,  32'h1000, 32'h80FF1234, 32'h80FF1234, "lw0");
        load_now(LD_B,  32'h1001, 32'h80FF1234, 32'h00000012, "lb1");
    endtask

    task automatic test_late();
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, LD_HU, 1'b1, 32'h3002, 32'h10C);
        step();
        i32.es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_blk", 64'(i32.ms_fwd_blk_bus[37]), 64'd1);
            chk("late_wait", 64'(i32.ms_to_ws_valid), 64'd0);
            step();
        end
        i32.data_sram_data_ok = 1'b1;
        i32.data_sram_rdata   = 32'h7654ABCD;
        #1;
        chk("late_valid", 64'(i32.ms_to_ws_valid), 64'd1);
        chk("late_data", 64'(i32.ms_to_ws_bus[63:32]), 64'h7654);
        chk("late_blk_off", 64'(i32.ms_fwd_blk_bus[37]), 64'd0);
        step();
        i32.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_backpressure();
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, LD_W, 1'b1, 32'h4000, 32'h110);
        step();
        i32.es_to_ms_valid    = 1'b0;
        i32.ws_allowin        = 1'b0;
        i32.data_sram_data_ok = 1'b1;
        i32.data_sram_rdata   = 32'hCAFEBABE;
        #1;
        chk("bp_allowin", 64'(i32.ms_allowin), 64'd0);
        step();
        i32.data_sram_data_ok = 1'b0;
        i32.data_sram_rdata   = 32'h0;
        #1;
        chk("bp_hold_valid", 64'(i32.ms_to_ws_valid), 64'd1);
        chk("bp_hold_data", 64'(i32.ms_to_ws_bus[63:32]), 64'hCAFEBABE);
        step();
        i32.ws_allowin      = 1'b1;
        i32.data_sram_rdata = 32'h11111111;
        #1;
        chk("bp_release", 64'(i32.ms_to_ws_bus[63:32]), 64'hCAFEBABE);
        step();
        chk("bp_drained", 64'(i32.ms_to_ws_valid), 64'd0);
    endtask

    task automatic test_flush();
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, LD_W, 1'b1, 32'h5000, 32'h114);
        step();
        i32.es_to_ms_valid = 1'b0;
        i32.flush          = 1'b1;
        #1;
        chk("fl_valid_masked", 64'(i32.ms_to_ws_valid), 64'd0);
        step();
        i32.flush = 1'b0;
        chk("fl_disc_one", 64'(d32.disc_cnt), 64'd1);
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, LD_W, 1'b1, 32'h6000, 32'h118);
        #1;
        chk("fl_allowin", 64'(i32.ms_allowin), 64'd1);
        step();
        i32.es_to_ms_valid    = 1'b0;
        i32.data_sram_data_ok = 1'b1;
        i32.data_sram_rdata   = 32'h0000DEAD;
        #1;
        chk("fl_stale_blk", 64'(i32.ms_fwd_blk_bus[37]), 64'd1);
        chk("fl_stale_hold", 64'(i32.ms_to_ws_valid), 64'd0);
        step();
        chk("fl_disc_zero", 64'(d32.disc_cnt), 64'd0);
        i32.data_sram_rdata = 32'h00001234;
        #1;
        chk("fl_new_valid", 64'(i32.ms_to_ws_valid), 64'd1);
        chk("fl_new_data", 64'(i32.ms_to_ws_bus[63:32]), 64'h1234);
        chk("fl_new_pc", 64'(i32.ms_to_ws_bus[31:0]), 64'h118);
        step();
        i32.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        i32.es_to_ms_valid = 1'b1;
        i32.es_to_ms_bus   = mk32(1'b1, LD_W, 1'b1, 32'h7000, 32'h11C);
        step();
        i32.es_to_ms_valid = 1'b0;
        i32.flush          = 1'b1;
        step();
        i32.flush = 1'b0;
        chk("rmw_disc_one", 64'(d32.disc_cnt), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rmw_disc_clr", 64'(d32.disc_cnt), 64'd0);
        chk("rmw_allowin", 64'(i32.ms_allowin), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic load64(input logic [2:0] ld, input logic [63:0] exp,
                          input string nm);
        i64.es_to_ms_valid = 1'b1;
        i64.es_to_ms_bus   = mk64(ld, 64'h2004);
        step();
        i64.es_to_ms_valid    = 1'b0;
        i64.data_sram_data_ok = 1'b1;
        i64.data_sram_rdata   = 64'h89ABCDEF_01234567;
        #1;
        chk({nm, "_valid"}, 64'(i64.ms_to_ws_valid), 64'd1);
        chk(nm, i64.ms_to_ws_bus[95:32], exp);
        step();
        i64.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_wide();
        load64(LD_WU, 64'h00000000_89ABCDEF, "w64_lwu4");
        load64(LD_W,  64'hFFFFFFFF_89ABCDEF, "w64_lw4");
        load64(LD_B,  64'hFFFFFFFF_FFFFFFEF, "w64_lb4");
        load64(LD_HU, 64'h00000000_0000CDEF, "w64_lhu4");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        i32.es_to_ms_valid = 1'b0;
        i32.es_to_ms_bus = '0;
        i32.ws_allowin = 1'b1;
        i32.flush = 1'b0;
        i32.data_sram_data_ok = 1'b0;
        i32.data_sram_rdata = '0;
        i64.es_to_ms_valid = 1'b0;
        i64.es_to_ms_bus = '0;
        i64.ws_allowin = 1'b1;
        i64.flush = 1'b0;
        i64.data_sram_data_ok = 1'b0;
        i64.data_sram_rdata = '0;
        test_reset();
        test_alu();
        test_align();
        test_late();
        test_backpressure();
        test_flush();
        test_reset_mid_wait();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
